// File: rtl/fetch_buffer_pkg.sv
// Shared constants for the fetch buffer slice.
//   FB_DEPTH      default number of queue entries (power of two, >= 4)
//   FB_INSN_LEN   instruction width
//   FB_ADDR_LEN   PC width
//   SLOT_SEL_HI/LO  position of the first-useful-slot field in the fetch PC
package fetch_buffer_pkg;

    localparam int FB_DEPTH    = 8;
    localparam int FB_INSN_LEN = 32;
    localparam int FB_ADDR_LEN = 32;

    localparam int SLOT_SEL_HI = 3;
    localparam int SLOT_SEL_LO = 2;

    localparam int LINE_SLOTS  = 4;

endpackage

// File: rtl/fb_ram.sv
// Entry storage for the fetch buffer.
//   clk          write clock
//   i_we         write enable for this cycle's line
//   i_wr_idx     first entry written
//   i_wr_cnt     number of consecutive entries written (1..4), wraps at DEPTH
//   i_wr_data    packed entries, entry j at [EW*j +: EW]
//   i_rd_idx0/1  combinational read addresses
//   o_rd_data0/1 read data
import fetch_buffer_pkg::*;

module fb_ram #(
    parameter int DEPTH = FB_DEPTH,
    parameter int EW    = FB_INSN_LEN + FB_ADDR_LEN,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      i_we,
    input  logic [AW-1:0]             i_wr_idx,
    input  logic [2:0]                i_wr_cnt,
    input  logic [LINE_SLOTS*EW-1:0]  i_wr_data,
    input  logic [AW-1:0]             i_rd_idx0,
    input  logic [AW-1:0]             i_rd_idx1,
    output logic [EW-1:0]             o_rd_data0,
    output logic [EW-1:0]             o_rd_data1
);

    logic [EW-1:0] r_mem [DEPTH];

    // Index arithmetic is AW bits wide, so a line running past the last
    // entry lands at the start of the array.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int j = 0; j < LINE_SLOTS; j++) begin
                if (3'(j) < i_wr_cnt) begin
                    r_mem[i_wr_idx + AW'(j)] <= i_wr_data[EW*j +: EW];
                end
            end
        end
    end

    assign o_rd_data0 = r_mem[i_rd_idx0];
    assign o_rd_data1 = r_mem[i_rd_idx1];

endmodule

// File: rtl/fetch_buffer.sv
// Instruction queue between the fetch port and decode.
//   clk, reset_n          clock, async active-low reset
//   line_valid, line_pc,  fetch line in; line_pc[3:2] is the first useful slot
//   idata
//   line_ready            room for a full 4-instruction line
//   kill_IF               flush everything on the next edge
//   stall_ID              decode not consuming
//   insn0/pc0/valid0      oldest instruction
//   insn1/pc1/valid1      second-oldest instruction
import fetch_buffer_pkg::*;

module fetch_buffer #(
    parameter int DEPTH    = FB_DEPTH,
    parameter int INSN_LEN = FB_INSN_LEN,
    parameter int ADDR_LEN = FB_ADDR_LEN
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         line_valid,
    input  logic [ADDR_LEN-1:0]          line_pc,
    input  logic [LINE_SLOTS*INSN_LEN-1:0] idata,
    output logic                         line_ready,
    input  logic                         kill_IF,
    input  logic                         stall_ID,
    output logic [INSN_LEN-1:0]          insn0,
    output logic [INSN_LEN-1:0]          insn1,
    output logic [ADDR_LEN-1:0]          pc0,
    output logic [ADDR_LEN-1:0]          pc1,
    output logic                         valid0,
    output logic                         valid1
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = INSN_LEN + ADDR_LEN;

    localparam logic [PW-1:0] DEPTH_P     = PW'(DEPTH);
    localparam logic [PW-1:0] READY_LIMIT = PW'(DEPTH - LINE_SLOTS);

    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [PW-1:0] w_count;
    logic [1:0]    w_slot;
    logic [2:0]    w_push_n;
    logic [1:0]    w_pop_n;
    logic          w_push;
    logic          w_pop;
    logic [LINE_SLOTS*EW-1:0] w_wr_data;
    logic [EW-1:0] w_rd0;
    logic [EW-1:0] w_rd1;
    logic          w_unused_pc_lsbs;

    assign w_unused_pc_lsbs = ^line_pc[SLOT_SEL_LO-1:0];

    assign w_count    = r_tail - r_head;
    assign line_ready = (w_count <= READY_LIMIT);
    assign valid0     = (w_count >= PW'(1));
    assign valid1     = (w_count >= PW'(2));

    assign w_slot   = line_pc[SLOT_SEL_HI:SLOT_SEL_LO];
    assign w_push_n = 3'd4 - {1'b0, w_slot};
    assign w_push   = line_valid & line_ready & ~kill_IF;
    assign w_pop    = ~stall_ID & ~kill_IF;
    assign w_pop_n  = {1'b0, valid0} + {1'b0, valid1};

    // Compact the useful slots so entry j of the write bus is slot (first+j).
    always_comb begin
        logic [1:0] k;
        w_wr_data = '0;
        for (int j = 0; j < LINE_SLOTS; j++) begin
            k = w_slot + 2'(j);
            w_wr_data[EW*j +: EW] = {line_pc[ADDR_LEN-1:4], k, 2'b00,
                                     idata[INSN_LEN*k +: INSN_LEN]};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head <= '0;
            r_tail <= '0;
        end else if (kill_IF) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + PW'(w_push_n);
            if (w_pop)  r_head <= r_head + PW'(w_pop_n);
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n) begin
            assert (w_count <= DEPTH_P);
        end
    end

    fb_ram #(
        .DEPTH (DEPTH),
        .EW    (EW)
    ) u_fb_ram (
        .clk        (clk),
        .i_we       (w_push),
        .i_wr_idx   (r_tail[AW-1:0]),
        .i_wr_cnt   (w_push_n),
        .i_wr_data  (w_wr_data),
        .i_rd_idx0  (r_head[AW-1:0]),
        .i_rd_idx1  (r_head[AW-1:0] + AW'(1)),
        .o_rd_data0 (w_rd0),
        .o_rd_data1 (w_rd1)
    );

    assign pc0   = w_rd0[EW-1:INSN_LEN];
    assign insn0 = w_rd0[INSN_LEN-1:0];
    assign pc1   = w_rd1[EW-1:INSN_LEN];
    assign insn1 = w_rd1[INSN_LEN-1:0];

endmodule
